// File: rtl/mem_arbiter.sv
// Shares the single RAM port between the icache fill path and the dcache path.
// Data wins by default; instruction is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state, nstate;
  logic [SW-1:0] scnt, scnt_n;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= nstate;
      scnt  <= scnt_n;
    end
  end

  always_comb begin
    nstate   = state;
    scnt_n   = scnt;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state)
      IDLE: begin
        if (dreq && !(iREN && scnt == SMAX)) nstate = DGRANT;
        else if (iREN)                        nstate = IGRANT;
      end

      DGRANT: begin
        ramaddr = daddr;
        // Strobes follow the live request so a dropped request never reaches RAM.
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN = 1'b1;
        end
        if (dreq && ramready) begin
          dwait = 1'b0;
          dload = dWEN ? 32'h0 : ramload;
          if (iREN && scnt != SMAX) scnt_n = scnt + 1'b1;
        end
        if (!dreq || ramready) nstate = IDLE;
      end

      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (iREN && ramready) begin
          iwait  = 1'b0;
          iload  = ramload;
          scnt_n = '0;
        end
        if (!iREN || ramready) nstate = IDLE;
      end

      default: nstate = IDLE;
    endcase

    // Starvation only accumulates while an instruction fetch is actually waiting.
    if (!iREN) scnt_n = '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic checked
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
  endtask

  task automatic do_reset();
    clr_in();
    nRST = 0;
    step();
    step();
    nRST = 1;
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_iwait"}, 32'(iwait), 32'd1);
    chk({p, "_dwait"}, 32'(dwait), 32'd1);
    chk({p, "_ramREN"}, 32'(ramREN), 32'd0);
    chk({p, "_ramWEN"}, 32'(ramWEN), 32'd0);
    chk({p, "_ramaddr"}, ramaddr, 32'd0);
    chk({p, "_ramstore"}, ramstore, 32'd0);
    chk({p, "_iload"}, iload, 32'd0);
    chk({p, "_dload"}, dload, 32'd0);
  endtask

  // Reference model state: who holds the port (0 none, 1 instr, 2 data) and how
  // many data grants have completed while the instruction side kept waiting.
  int          owner;
  int          passes;
  logic        e_iwait, e_dwait, e_ren, e_wen;
  logic [31:0] e_iload, e_dload, e_addr, e_store;

  int comp[$];
  logic want;

  initial begin
    clr_in();
    nRST = 1;
    #2 nRST = 0;
    #1;
    chk_quiet("por");
    step();
    nRST = 1;

    // Reset arriving in the middle of a data grant
    dREN = 1; daddr = 32'h40;
    step();
    #2;
    chk("t1_strobe", 32'(ramREN), 32'd1);
    chk("t1_addr", ramaddr, 32'h40);
    nRST = 0;
    #1;
    chk_quiet("t1_rst");
    step();
    nRST = 1;
    #2;
    chk_quiet("t1_idle");

    // Lone instruction fetch, RAM answers two cycles after the strobe
    do_reset();
    iREN = 1; iaddr = 32'h100;
    #2;
    chk("t2_c0_ren", 32'(ramREN), 32'd0);
    step(); #2;
    chk("t2_c1_ren", 32'(ramREN), 32'd1);
    chk("t2_c1_addr", ramaddr, 32'h100);
    chk("t2_c1_iwait", 32'(iwait), 32'd1);
    step(); #2;
    chk("t2_c2_iwait", 32'(iwait), 32'd1);
    step();
    ramready = 1; ramload = 32'hDEADBEEF;
    #2;
    chk("t2_done_iwait", 32'(iwait), 32'd0);
    chk("t2_done_iload", iload, 32'hDEADBEEF);
    chk("t2_done_dwait", 32'(dwait), 32'd1);
    step();
    ramready = 0; ramload = 0; iREN = 0;
    #2;
    chk_quiet("t2_after");

    // Simultaneous requests: data first, instruction after one idle cycle
    do_reset();
    iREN = 1; iaddr = 32'h0; dREN = 1; daddr = 32'h200;
    step(); #2;
    chk("t3_d_addr", ramaddr, 32'h200);
    chk("t3_d_ren", 32'(ramREN), 32'd1);
    chk("t3_d_iwait", 32'(iwait), 32'd1);
    step();
    ramready = 1; ramload = 32'h0000A5A5;
    #2;
    chk("t3_d_dwait", 32'(dwait), 32'd0);
    chk("t3_d_dload", dload, 32'h0000A5A5);
    chk("t3_d_iload", iload, 32'd0);
    step();
    ramready = 0; dREN = 0;
    #2;
    chk("t3_gap_ren", 32'(ramREN), 32'd0);
    step(); #2;
    chk("t3_i_ren", 32'(ramREN), 32'd1);
    chk("t3_i_addr", ramaddr, 32'h0);
    step();
    ramready = 1; ramload = 32'h11112222;
    #2;
    chk("t3_i_iwait", 32'(iwait), 32'd0);
    chk("t3_i_iload", iload, 32'h11112222);
    chk("t3_i_dwait", 32'(dwait), 32'd1);
    step();
    clr_in();

    // Starvation: both sides hold their requests, RAM answers one cycle after strobe
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h300;
    want = 0;
    for (int c = 0; c < 33; c++) begin
      step();
      ramready = want;
      ramload = 32'(c);
      #2;
      if (!dwait) comp.push_back(2);
      if (!iwait) comp.push_back(1);
      want = (ramREN | ramWEN) && !ramready;
    end
    chk("t4_ncomp", 32'(comp.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++)
      if (k < comp.size())
        chk($sformatf("t4_seq%0d", k), 32'(comp[k]), (k % 5 == 4) ? 32'd1 : 32'd2);
    clr_in();

    // Write with dREN also high: write wins, no load data returned
    do_reset();
    dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    step(); #2;
    chk("t5_wen", 32'(ramWEN), 32'd1);
    chk("t5_ren", 32'(ramREN), 32'd0);
    chk("t5_store", ramstore, 32'h12345678);
    chk("t5_addr", ramaddr, 32'h80);
    chk("t5_dwait_pre", 32'(dwait), 32'd1);
    step();
    ramready = 1; ramload = 32'hFFFFFFFF;
    #2;
    chk("t5_dwait", 32'(dwait), 32'd0);
    chk("t5_dload", dload, 32'd0);
    step();
    clr_in();

    // Data request withdrawn inside the grant
    do_reset();
    dREN = 1; daddr = 32'h40;
    step(); #2;
    chk("t6_ren_on", 32'(ramREN), 32'd1);
    step();
    dREN = 0;
    #2;
    chk("t6_ren_off", 32'(ramREN), 32'd0);
    chk("t6_dwait", 32'(dwait), 32'd1);
    step();
    dREN = 1;
    #2;
    chk("t6_idle_ren", 32'(ramREN), 32'd0);
    chk("t6_idle_dwait", 32'(dwait), 32'd1);
    step(); #2;
    chk("t6_regrant", 32'(ramREN), 32'd1);
    step();
    clr_in();

    // Random traffic against the model
    do_reset();
    owner = 0;
    passes = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      if ($urandom_range(9) == 0) iREN = ~iREN;
      if ($urandom_range(5) == 0) dREN = ~dREN;
      if ($urandom_range(7) == 0) dWEN = ~dWEN;
      ramready = ($urandom_range(2) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      #2;

      e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
      e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
      if (owner == 2) begin
        e_addr = daddr;
        e_wen = dWEN;
        e_ren = dREN && !dWEN;
        e_store = dWEN ? dstore : 32'h0;
        if ((dREN || dWEN) && ramready) begin
          e_dwait = 0;
          e_dload = dWEN ? 32'h0 : ramload;
        end
      end else if (owner == 1) begin
        e_addr = iaddr;
        e_ren = iREN;
        if (iREN && ramready) begin
          e_iwait = 0;
          e_iload = ramload;
        end
      end

      chk("rnd_iwait", 32'(iwait), 32'(e_iwait));
      chk("rnd_dwait", 32'(dwait), 32'(e_dwait));
      chk("rnd_ramREN", 32'(ramREN), 32'(e_ren));
      chk("rnd_ramWEN", 32'(ramWEN), 32'(e_wen));
      chk("rnd_ramaddr", ramaddr, e_addr);
      chk("rnd_ramstore", ramstore, e_store);
      chk("rnd_iload", iload, e_iload);
      chk("rnd_dload", dload, e_dload);

      // Advance the model to the next cycle
      if (owner == 0) begin
        if ((dREN || dWEN) && !(iREN && passes == LIM)) owner = 2;
        else if (iREN) owner = 1;
      end else if (owner == 2) begin
        if (!e_dwait && iREN) passes = (passes < LIM) ? passes + 1 : LIM;
        if (!(dREN || dWEN) || ramready) owner = 0;
      end else begin
        if (!e_iwait) passes = 0;
        if (!iREN || ramready) owner = 0;
      end
      if (!iREN) passes = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
